uart_prog_loader: RTL and testbench
===================================

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: system clocks per UART bit; legal range 4..4095.
REQ-002 Parameter ADDR_W, default 10: instruction-memory word-address width.
REQ-003 Parameter TIMEOUT_CYCLES, default 65536: idle-line timeout; used only when LOADER_TIMEOUT_EN is defined.
REQ-004 Ports, in order:
- clk_i, input, 1: the single clock.
- rst_ni, input, 1: asynchronous active-low reset.
- rx_i, input, 1: UART serial input; idle high.
- prog_ready_o, output, 1: loader is accepting a program; drives mprj_io[37].
- imem_we_o, output, 1: instruction-memory write strobe.
- imem_addr_o, output, ADDR_W: word address of the write.
- imem_wdata_o, output, 32: write data.
- load_done_o, output, 1: program load is complete.
- core_rst_no, output, 1: active-low reset to the core.
- frame_err_o, output, 1: sticky framing-error flag.

Function
REQ-005 rx_i SHALL pass through a 2-flop synchronizer before any use; the reset value of both flops is 1.
REQ-006 The RX FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE -> START when the synchronized rx is 0.
REQ-007 In START the FSM SHALL wait CLKS_PER_BIT/2 cycles, then resample.
- Sample 1: false start, return to IDLE with no byte.
- Sample 0: go to DATA.
REQ-008 In DATA the FSM SHALL sample 8 bits, LSB first, one every CLKS_PER_BIT cycles, then go to STOP.
REQ-009 In STOP the FSM SHALL sample once after CLKS_PER_BIT cycles.
- Sample 1: pulse an internal byte_valid for 1 cycle.
- Sample 0: set frame_err_o and discard the byte.
- Either case: return to IDLE.
REQ-010 The packer SHALL assemble bytes little-endian: the first byte of a word goes to [7:0] and the fourth to [31:24]. A 2-bit byte counter wraps 3 -> 0.
REQ-011 The cycle after the fourth byte_valid:
- If the word is not 32'h00000FFF, imem_we_o SHALL be high for exactly 1 cycle, with imem_addr_o and imem_wdata_o valid in that same cycle.
- If the word equals 32'h00000FFF (sentinel), it SHALL NOT be written and the loader enters DONE.
REQ-012 imem_addr_o SHALL start at 0 and increment by 1 in the cycle after each write.
REQ-013 A write to address 2^ADDR_W-1 SHALL enter DONE in the following cycle; the address SHALL NOT wrap.
REQ-014 prog_ready_o SHALL be 1 from the first clock edge after reset release until DONE, then 0.
REQ-015 In DONE:
- load_done_o = 1 and core_rst_no = 1.
- Further RX bytes SHALL be ignored.
- imem_we_o SHALL stay 0 until the next reset.
REQ-016 A byte_valid arriving in the same cycle as a write SHALL be accepted without loss; the write uses the previously packed word.
REQ-017 frame_err_o SHALL stay set until reset; framing errors SHALL NOT reset the byte counter.
REQ-018 Register outputs SHALL have no combinational path from rx_i.

Reset
REQ-019 rst_ni low SHALL asynchronously clear every register, with these output values:
- prog_ready_o = 0, imem_we_o = 0, imem_addr_o = 0, imem_wdata_o = 0.
- load_done_o = 0, core_rst_no = 0, frame_err_o = 0.
- RX FSM = IDLE, byte counter = 0.
REQ-020 Reset asserted mid-byte or mid-word SHALL discard the partial data; after release, loading restarts at address 0.
REQ-021 Reset release SHALL be synchronized internally (2-flop) before it affects the FSMs.

Configuration
REQ-022 Macro LOADER_TIMEOUT_EN:
- Defined: after at least one word has been written, the loader SHALL enter DONE when no start bit is detected for TIMEOUT_CYCLES consecutive cycles; a partial word is discarded.
- Not defined: DONE is reached only via the sentinel or the last address, and no timeout counter is instantiated.

Verification
REQ-023 Send bytes 13 00 00 00 then FF 0F 00 00 at CLKS_PER_BIT=16 -> one write (addr 0, data 32'h00000013); then load_done_o=1, core_rst_no=1, prog_ready_o=0.
REQ-024 Send 3 words followed by the sentinel -> writes at addresses 0, 1, 2 with correct little-endian data, each strobe 1 cycle wide.
REQ-025 Send a byte with stop bit 0, then a valid word -> frame_err_o=1; the word is still written at addr 0, and only 3 of its bytes complete it if the bad byte was discarded mid-word.
REQ-026 Pulse rx_i low for 4 cycles -> no byte, no write, no error.
REQ-027 ADDR_W=2, send 4 words -> writes at addresses 0..3, then DONE with no sentinel.
REQ-028 Assert rst_ni after 2 bytes, release, then send 1 word + sentinel -> write at addr 0 with the new data only; with LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=1000, one word then an idle line -> DONE within 1000 cycles of the last stop bit.

Source files
------------

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART-fed instruction-memory loader that holds the core in reset until the program is in.
// Optional idle-line timeout to DONE is enabled by defining LOADER_TIMEOUT_EN.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT   = 16,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rx_i,
  output logic              prog_ready_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       imem_wdata_o,
  output logic              load_done_o,
  output logic              core_rst_no,
  output logic              frame_err_o
);
  localparam logic [11:0] BIT_END  = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF_END = 12'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0] SENTINEL = 32'h0000_0FFF;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  logic [1:0]        r_rst_sync;
  logic              r_rx_meta, r_rx;
  rx_state_t         r_state;
  logic [11:0]       r_cnt;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_byte_valid, r_frame_err;
  logic [31:0]       r_word, r_wdata;
  logic [1:0]        r_bcnt;
  logic              r_we, r_done, r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              w_run, w_last, w_timeout, w_done_nxt;
  logic [31:0]       w_full;
  assign w_run = r_rst_sync[1];
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_rst_sync <= 2'b00;
    else r_rst_sync <= {r_rst_sync[0], 1'b1};
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) {r_rx_meta, r_rx} <= 2'b11;
    else {r_rx_meta, r_rx} <= {rx_i, r_rx_meta};
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      if (w_run)
        case (r_state)
          IDLE: begin
            r_cnt <= '0;
            if (!r_rx) r_state <= START;
          end
          START:
            if (r_cnt == HALF_END) begin
              r_cnt   <= '0;
              r_bit   <= '0;
              r_state <= r_rx ? IDLE : DATA;
            end else r_cnt <= r_cnt + 12'd1;
          DATA:
            if (r_cnt == BIT_END) begin
              r_cnt   <= '0;
              r_shift <= {r_rx, r_shift[7:1]};
              r_bit   <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_state <= STOP;
            end else r_cnt <= r_cnt + 12'd1;
          STOP:
            if (r_cnt == BIT_END) begin
              r_cnt        <= '0;
              r_state      <= IDLE;
              r_byte_valid <= r_rx;
              if (!r_rx) r_frame_err <= 1'b1;
            end else r_cnt <= r_cnt + 12'd1;
          default: r_state <= IDLE;
        endcase
    end
  // The fourth byte is still in r_shift when it is judged, so the word is formed on the fly.
  assign w_full     = {r_shift, r_word[23:0]};
  assign w_last     = r_byte_valid && r_bcnt == 2'd3 && !r_done;
  assign w_done_nxt = r_done || (w_last && w_full == SENTINEL) || (r_we && r_addr == '1) || w_timeout;
`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;
  logic          r_wrote;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_to_cnt <= '0;
      r_wrote  <= 1'b0;
    end else begin
      if (r_we) r_wrote <= 1'b1;
      if (r_state != IDLE || !r_rx) r_to_cnt <= '0;
      else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) r_to_cnt <= r_to_cnt + 1'b1;
    end
  assign w_timeout = r_wrote && r_to_cnt == TW'(TIMEOUT_CYCLES);
`else
  assign w_timeout = 1'b0;
`endif
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_word  <= '0;
      r_bcnt  <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_done  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_done  <= w_done_nxt;
      r_ready <= !w_done_nxt;
      r_we    <= w_last && w_full != SENTINEL;
      if (r_byte_valid && !r_done) begin
        r_word[{r_bcnt, 3'b000} +: 8] <= r_shift;
        r_bcnt <= r_bcnt + 2'd1;
      end
      if (w_last && w_full != SENTINEL) r_wdata <= w_full;
      if (r_we && r_addr != '1) r_addr <= r_addr + 1'b1;
    end
  assign prog_ready_o = r_ready;
  assign imem_we_o    = r_we;
  assign imem_addr_o  = r_addr;
  assign imem_wdata_o = r_wdata;
  assign load_done_o  = r_done;
  assign core_rst_no  = r_done;
  assign frame_err_o  = r_frame_err;
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed, table-driven bench for uart_prog_loader.
module tb_uart_prog_loader;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rx2 = 1'b1;
  logic ready, we, done, crst, ferr, ready2, we2, done2, crst2, ferr2;
  logic [9:0] addr;
  logic [1:0] addr2;
  logic [31:0] wdata, wdata2;
  int n_chk = 0, n_fail = 0, n_wr = 0, n_wr2 = 0, n_wide = 0, base = 0;
  logic [9:0] wa[64];
  logic [31:0] wd[64];
  logic [1:0] wa2[8];
  logic [31:0] wd2[8];
  logic pwe = 1'b0, pwe2 = 1'b0;
  typedef struct {logic [7:0] b0, b1, b2, b3; logic [31:0] data; logic [9:0] addr;} vec_t;
  vec_t tbl[3];

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(16), .ADDR_W(10), .TIMEOUT_CYCLES(1000)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .prog_ready_o(ready), .imem_we_o(we),
    .imem_addr_o(addr), .imem_wdata_o(wdata), .load_done_o(done), .core_rst_no(crst),
    .frame_err_o(ferr));
  uart_prog_loader #(.CLKS_PER_BIT(16), .ADDR_W(2), .TIMEOUT_CYCLES(1000)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx2), .prog_ready_o(ready2), .imem_we_o(we2),
    .imem_addr_o(addr2), .imem_wdata_o(wdata2), .load_done_o(done2), .core_rst_no(crst2),
    .frame_err_o(ferr2));

  always @(negedge clk) begin
    if (we && n_wr < 64) begin wa[n_wr] = addr; wd[n_wr] = wdata; n_wr++; end
    if (we2 && n_wr2 < 8) begin wa2[n_wr2] = addr2; wd2[n_wr2] = wdata2; n_wr2++; end
    if ((we && pwe) || (we2 && pwe2)) n_wide++;
    pwe = we;
    pwe2 = we2;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int t, input logic v);
    if (t == 0) rx = v; else rx2 = v;
  endtask

  task automatic send_byte(input int t, input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      drive(t, f[i]);
      repeat (16) @(negedge clk);
    end
    drive(t, 1'b1);
    repeat (8) @(negedge clk);
  endtask

  task automatic send_word(input int t, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(t, w[8*i +: 8], 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h1234_5678, 10'd0};
    tbl[1] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 32'hDEAD_BEEF, 10'd1};
    tbl[2] = '{8'h01, 8'h00, 8'h00, 8'h80, 32'h8000_0001, 10'd2};
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_done", done, 0);
    check("rst_core_rst_n", crst, 0);
    check("rst_ferr", ferr, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("ready_first_edge", ready, 1);
    repeat (4) @(negedge clk);
    // Short glitch: must be rejected as a false start.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_no_write", n_wr, 0);
    check("glitch_no_ferr", ferr, 0);
    base = n_wr;
    send_word(0, 32'h0000_0013);
    send_word(0, 32'h0000_0FFF);
    repeat (5) @(negedge clk);
    check("basic_nwr", n_wr - base, 1);
    check("basic_addr", wa[base], 0);
    check("basic_data", wd[base], 32'h13);
    check("basic_done", done, 1);
    check("basic_core_rst_n", crst, 1);
    check("basic_ready", ready, 0);
    send_word(0, 32'hCAFE_F00D);
    check("done_ignores_rx", n_wr - base, 1);
    check("done_no_we", we, 0);
    do_reset();
    check("reset_clears_done", done, 0);
    base = n_wr;
    for (int i = 0; i < 3; i++) begin
      send_byte(0, tbl[i].b0, 1'b1);
      send_byte(0, tbl[i].b1, 1'b1);
      send_byte(0, tbl[i].b2, 1'b1);
      send_byte(0, tbl[i].b3, 1'b1);
    end
    send_word(0, 32'h0000_0FFF);
    repeat (5) @(negedge clk);
    check("tbl_nwr", n_wr - base, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("tbl_addr%0d", i), wa[base + i], tbl[i].addr);
      check($sformatf("tbl_data%0d", i), wd[base + i], tbl[i].data);
    end
    check("tbl_done", done, 1);
    do_reset();
    base = n_wr;
    send_byte(0, 8'h11, 1'b1);
    send_byte(0, 8'h22, 1'b1);
    send_byte(0, 8'hAA, 1'b0);
    check("ferr_set", ferr, 1);
    send_byte(0, 8'h33, 1'b1);
    send_byte(0, 8'h44, 1'b1);
    send_word(0, 32'h0000_0FFF);
    repeat (5) @(negedge clk);
    check("ferr_nwr", n_wr - base, 1);
    check("ferr_addr", wa[base], 0);
    check("ferr_data", wd[base], 32'h4433_2211);
    check("ferr_sticky", ferr, 1);
    do_reset();
    check("ferr_cleared", ferr, 0);
    base = n_wr;
    send_byte(0, 8'hAA, 1'b1);
    send_byte(0, 8'hBB, 1'b1);
    do_reset();
    send_word(0, 32'h0403_0201);
    send_word(0, 32'h0000_0FFF);
    repeat (5) @(negedge clk);
    check("midrst_nwr", n_wr - base, 1);
    check("midrst_addr", wa[base], 0);
    check("midrst_data", wd[base], 32'h0403_0201);
    for (int i = 0; i < 4; i++) send_word(1, {4{8'(8'h11 * (i + 1))}});
    repeat (5) @(negedge clk);
    check("aw2_nwr", n_wr2, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("aw2_addr%0d", i), 32'(wa2[i]), i);
      check($sformatf("aw2_data%0d", i), wd2[i], {4{8'(8'h11 * (i + 1))}});
    end
    check("aw2_done", done2, 1);
    check("aw2_ready", ready2, 0);
    do_reset();
    base = n_wr;
    send_word(0, 32'h0000_0055);
    repeat (1010) @(negedge clk);
    check("idle_nwr", n_wr - base, 1);
`ifdef LOADER_TIMEOUT_EN
    check("timeout_done", done, 1);
`else
    check("no_timeout_done", done, 0);
`endif
    check("strobe_width", n_wide, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
